// File: rtl/chunked_add_sequencer.sv
// Wide adder that sums BIT_NUMBER-bit operands CHUNK_WIDTH bits per cycle through one CLA slice.
// Define ADDSEQ_SUB_EN to add the in_sub port (X - Y via inverted Y and carry-in of 1).

module nbit_cla_full_adder #(
   parameter int BIT_NUMBER = 16
) (
   input  logic [BIT_NUMBER:1] a,
   input  logic [BIT_NUMBER:1] b,
   input  logic                c_in,
   output logic [BIT_NUMBER:1] s,
   output logic                c_out
);

   logic [BIT_NUMBER:1]   g;
   logic [BIT_NUMBER:1]   p;
   logic [BIT_NUMBER+1:1] c;
   logic                  cy;
   logic                  pp;

   // Each carry is expanded as a flat sum of products of generate/propagate terms and c_in.
   always_comb begin
      g    = a & b;
      p    = a ^ b;
      c    = '0;
      cy   = 1'b0;
      pp   = 1'b1;
      c[1] = c_in;
      for (int i = 1; i <= BIT_NUMBER; i++) begin
         cy = 1'b0;
         pp = 1'b1;
         for (int j = i; j >= 1; j--) begin
            cy = cy | (pp & g[j]);
            pp = pp & p[j];
         end
         c[i+1] = cy | (pp & c_in);
      end
      s = p ^ c[BIT_NUMBER:1];
   end

   assign c_out = c[BIT_NUMBER+1];

endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | adding chunk k into out_sum, carry held in carry_q
// DONE  | result held on out_sum/out_cout, out_valid=1
module chunked_add_sequencer #(
   parameter int BIT_NUMBER  = 64,
   parameter int CHUNK_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [BIT_NUMBER-1:0] in_x,
   input  logic [BIT_NUMBER-1:0] in_y,
   input  logic                  in_cin,
`ifdef ADDSEQ_SUB_EN
   input  logic                  in_sub,
`endif
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BIT_NUMBER-1:0] out_sum,
   output logic                  out_cout
);

   localparam int NCHUNK = BIT_NUMBER / CHUNK_WIDTH;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [KW-1:0]         k_q, k_d;
   logic [BIT_NUMBER-1:0] x_q, x_d;
   logic [BIT_NUMBER-1:0] y_q, y_d;
   logic                  carry_q, carry_d;
   logic [BIT_NUMBER-1:0] sum_q, sum_d;
   logic                  cout_q, cout_d;

   logic [31:0]           lo_bit;
   logic [CHUNK_WIDTH:1]  sl_a, sl_b, sl_s;
   logic                  sl_cout;

   assign lo_bit = 32'(k_q) * 32'(CHUNK_WIDTH);
   assign sl_a   = x_q[lo_bit +: CHUNK_WIDTH];
   assign sl_b   = y_q[lo_bit +: CHUNK_WIDTH];

   nbit_cla_full_adder #(
      .BIT_NUMBER(CHUNK_WIDTH)
   ) u_slice (
      .a    (sl_a),
      .b    (sl_b),
      .c_in (carry_q),
      .s    (sl_s),
      .c_out(sl_cout)
   );

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      x_d     = x_q;
      y_d     = y_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               x_d     = in_x;
               y_d     = in_y;
               carry_d = in_cin;
`ifdef ADDSEQ_SUB_EN
               if (in_sub) begin
                  y_d     = ~in_y;
                  carry_d = 1'b1;
               end
`endif
               k_d     = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            sum_d[lo_bit +: CHUNK_WIDTH] = sl_s;
            carry_d = sl_cout;
            k_d     = k_q + KW'(1);
            if (k_q == K_LAST) begin
               cout_d  = sl_cout;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         x_q     <= '0;
         y_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         x_q     <= x_d;
         y_q     <= y_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;

endmodule

// File: doc/chunked_add_sequencer.md
# chunked_add_sequencer

Multi-cycle wide adder built around a narrow carry-lookahead slice. It accepts two BIT_NUMBER-bit operands over a valid/ready handshake and adds them CHUNK_WIDTH bits per cycle. The carry is registered between chunks. The full sum and carry-out are presented on a valid/ready output port. It sits directly upstream of the wide-adder result consumers. Its datapath core is one instance of the team's nbit CLA full adder, with BIT_NUMBER set to CHUNK_WIDTH.

## Interface
- BIT_NUMBER, 64, operand width; must be an integer multiple of CHUNK_WIDTH
- CHUNK_WIDTH, 16, slice width added per cycle; NCHUNK = BIT_NUMBER/CHUNK_WIDTH

- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- in_x  input  BIT_NUMBER  operand X
- in_y  input  BIT_NUMBER  operand Y
- in_cin  input  1  initial carry-in
- in_sub  input  1  subtract request (present only with ADDSEQ_SUB_EN)
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_sum  output  BIT_NUMBER  sum bits
- out_cout  output  1  final carry-out

## Operation
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE -> RUN on in_valid && in_ready:
  - latch in_x, in_y and in_cin into the carry register.
  - clear the chunk index k to 0.
- RUN, each cycle:
  - slice adds x[k*CW +: CW], y[k*CW +: CW] and the carry register.
  - slice sum is taken from CLA output bits S[CW:1]; slice carry from Cout.
  - at the edge, sum is written into out_sum[k*CW +: CW] and the carry register is updated.
  - k increments.
- RUN -> DONE on the edge that writes chunk NCHUNK-1; out_cout = final carry at that edge.
- DONE -> IDLE on out_valid && out_ready.
- No overlap: a new operand pair is accepted only in IDLE.
- Arithmetic: {out_cout, out_sum} = in_x + in_y + in_cin, modulo 2^(BIT_NUMBER+1).
- out_sum is rewritten chunk-by-chunk during RUN. It is only meaningful while out_valid=1.
- Inputs are sampled only at the accept edge; changes afterwards are ignored.
- Reset (any state, including mid-RUN or DONE):
  - state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, k=0, carry register=0.
  - any in-flight operation is discarded.

## Timing
- Accept at edge E0; chunk i is registered at edge E(i+1).
- out_valid rises after edge E(NCHUNK): latency NCHUNK cycles (4 at defaults).
- out_valid, out_sum and out_cout are held stable while out_valid && !out_ready.
- in_ready rises in the cycle after the output handshake edge.
- Best-case throughput: one operation per NCHUNK+2 cycles.
- in_ready and out_valid are registered-state decodes; there is no combinational path from in_valid or out_ready to them.
- out_ready asserted while not in DONE has no effect.

## Configuration
- ADDSEQ_SUB_EN defined:
  - port in_sub exists and is latched at accept.
  - when in_sub=1, the latched Y is stored bitwise inverted and the carry register is loaded with 1; in_cin is ignored.
  - result = X − Y; out_cout = 1 means no borrow.
  - when in_sub=0, behaviour is identical to add.
- ADDSEQ_SUB_EN undefined:
  - port in_sub is absent.
  - the block only adds: X + Y + in_cin.

## Test plan
- Reset values: assert rst_n=0 asynchronously mid-cycle -> immediately in_ready=1, out_valid=0, out_sum=0, out_cout=0.
- Full carry ripple: X=0xFFFF_FFFF_FFFF_FFFF, Y=0, cin=1 -> out_sum=0, out_cout=1; out_valid exactly 4 cycles after accept.
- Chunk-boundary carry: X=0x0000_0000_0000_FFFF, Y=1, cin=0 -> out_sum=0x0000_0000_0001_0000, out_cout=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_valid, out_sum and out_cout stay constant, in_ready=0 throughout, and in_valid is ignored. Release out_ready -> in_ready=1 the next cycle.
- Reset mid-RUN: assert rst_n low after 2 chunks have completed -> reset values. A following op 3+4 (cin=0) -> out_sum=7, out_cout=0.
- With ADDSEQ_SUB_EN, in_sub=1:
  - X=5, Y=7 -> out_sum=0xFFFF_FFFF_FFFF_FFFE, out_cout=0.
  - X=7, Y=5 -> out_sum=2, out_cout=1.
